// File: rtl/timer_sequencer.sv
`timescale 1ns/1ps
// Countdown datapath: 1 Hz tick prescaler, preset load and mm:ss BCD down-counter.
// Optional low-time blink on warn when TIMER_WARN_BLINK_EN is defined.
module timer_sequencer #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter logic [15:0] PRESET_A = 16'h0030,
  parameter logic [15:0] PRESET_B = 16'h0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  state,
  output logic [15:0] bcd,
  output logic        zero,
  output logic        done,
  output logic        tick,
  output logic        warn
);

  localparam int unsigned   PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE1 = 2'b00,
    ST_IDLE2 = 2'b01,
    ST_RUN   = 2'b10,
    ST_STOP  = 2'b11
  } ctrl_state_e;

  ctrl_state_e   st;
  logic [PW-1:0] presc, presc_nxt;
  logic [15:0]   bcd_nxt;
  logic          wrap;
  logic          done_nxt;

  assign st = ctrl_state_e'(state);

  // Minute/second BCD decrement; never called with 0000.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] d3, d2, d1, d0;
    logic       b;
    {d3, d2, d1, d0} = v;
    b = 1'b0;
    if (d0 != 4'd0) d0 = d0 - 4'd1;
    else begin
      d0 = 4'd9;
      b  = 1'b1;
    end
    if (b) begin
      if (d1 != 4'd0) begin
        d1 = d1 - 4'd1;
        b  = 1'b0;
      end else begin
        d1 = 4'd5;
      end
    end
    if (b) begin
      if (d2 != 4'd0) begin
        d2 = d2 - 4'd1;
        b  = 1'b0;
      end else begin
        d2 = 4'd9;
      end
    end
    if (b) d3 = d3 - 4'd1;
    return {d3, d2, d1, d0};
  endfunction

  always_comb begin
    wrap      = (st == ST_RUN) && (presc == PRESC_LAST);
    presc_nxt = presc;
    bcd_nxt   = bcd;
    done_nxt  = 1'b0;
    case (st)
      ST_IDLE1: begin
        presc_nxt = '0;
        bcd_nxt   = PRESET_A;
      end
      ST_IDLE2: begin
        presc_nxt = '0;
        bcd_nxt   = PRESET_B;
      end
      ST_RUN: begin
        presc_nxt = wrap ? '0 : presc + PW'(1);
        if (wrap && (bcd != 16'h0000)) begin
          bcd_nxt  = bcd_dec(bcd);
          done_nxt = (bcd == 16'h0001);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      bcd   <= PRESET_A;
      zero  <= 1'b0;
      done  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      presc <= presc_nxt;
      bcd   <= bcd_nxt;
      zero  <= (bcd_nxt == 16'h0000);
      done  <= done_nxt;
      tick  <= wrap;
    end
  end

`ifdef TIMER_WARN_BLINK_EN
  logic warn_q;
  logic in_band;

  // Band is judged on the value bcd is about to take, so warn drops with the final decrement.
  assign in_band = (bcd_nxt != 16'h0000) && (bcd_nxt[15:4] == 12'h000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warn_q <= 1'b0;
    end else if ((st == ST_RUN) && in_band) begin
      if (wrap || (presc == PRESC_HALF)) warn_q <= ~warn_q;
    end else begin
      warn_q <= 1'b0;
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_timer_sequencer.sv
`timescale 1ns/1ps
// Bench for timer_sequencer: two instances (default presets, short presets) against a seconds-based model.
module tb_timer_sequencer;

  logic        clk;
  logic        rst_n;
  logic [1:0]  state;
  logic [15:0] bcd_a, bcd_b;
  logic        zero_a, done_a, tick_a, warn_a;
  logic        zero_b, done_b, tick_b, warn_b;

  int checks;
  int errors;

  // Model state per instance, held as plain seconds rather than BCD.
  int secs [2];
  int presc[2];
  int pa   [2];
  int pb   [2];
  bit zero_m[2], done_m[2], tick_m[2], warn_m[2];

  timer_sequencer #(.TICK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .state(state),
    .bcd(bcd_a), .zero(zero_a), .done(done_a), .tick(tick_a), .warn(warn_a)
  );

  timer_sequencer #(.TICK_DIV(4), .PRESET_A(16'h0002), .PRESET_B(16'h0005)) dut_b (
    .clk(clk), .rst_n(rst_n), .state(state),
    .bcd(bcd_b), .zero(zero_b), .done(done_b), .tick(tick_b), .warn(warn_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      secs[i]   = pa[i];
      presc[i]  = 0;
      zero_m[i] = 1'b0;
      done_m[i] = 1'b0;
      tick_m[i] = 1'b0;
      warn_m[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [1:0] st);
    for (int i = 0; i < 2; i++) begin
      int old_s, old_p;
      bit wr;
      old_s = secs[i];
      old_p = presc[i];
      wr    = (st == 2'b10) && (old_p == 3);
      case (st)
        2'b00: begin secs[i] = pa[i]; presc[i] = 0; end
        2'b01: begin secs[i] = pb[i]; presc[i] = 0; end
        2'b10: begin
          presc[i] = (old_p + 1) % 4;
          if (wr && old_s > 0) secs[i] = old_s - 1;
        end
        default: ;
      endcase
      tick_m[i] = wr;
      done_m[i] = wr && (old_s == 1);
      zero_m[i] = (secs[i] == 0);
`ifdef TIMER_WARN_BLINK_EN
      if (st == 2'b10 && secs[i] >= 1 && secs[i] <= 9) begin
        if (old_p == 1 || wr) warn_m[i] = !warn_m[i];
      end else begin
        warn_m[i] = 1'b0;
      end
`else
      warn_m[i] = 1'b0;
`endif
    end
  endtask

  task automatic compare_all();
    chk("a.bcd",  bcd_a,  to_bcd(secs[0]));
    chk("a.zero", 16'(zero_a), 16'(zero_m[0]));
    chk("a.done", 16'(done_a), 16'(done_m[0]));
    chk("a.tick", 16'(tick_a), 16'(tick_m[0]));
    chk("a.warn", 16'(warn_a), 16'(warn_m[0]));
    chk("b.bcd",  bcd_b,  to_bcd(secs[1]));
    chk("b.zero", 16'(zero_b), 16'(zero_m[1]));
    chk("b.done", 16'(done_b), 16'(done_m[1]));
    chk("b.tick", 16'(tick_b), 16'(tick_m[1]));
    chk("b.warn", 16'(warn_b), 16'(warn_m[1]));
  endtask

  task automatic cyc(input logic [1:0] st);
    @(negedge clk);
    state = st;
    @(posedge clk);
    model_step(st);
    #1;
    compare_all();
  endtask

  task automatic cycn(input logic [1:0] st, input int n);
    for (int k = 0; k < n; k++) cyc(st);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // Presets expressed in seconds: 00:30, 01:00, 00:02, 00:05.
    pa[0] = 30; pb[0] = 60;
    pa[1] = 2;  pb[1] = 5;
    rst_n = 1'b0;
    state = 2'b00;
    model_reset();
    #12;
    compare_all();
    chk("reset.bcd_a", bcd_a, 16'h0030);
    @(negedge clk);
    rst_n = 1'b1;

    // First decrement on the 4th RUN edge.
    cycn(2'b00, 2);
    cycn(2'b10, 3);
    chk("run3.bcd_a", bcd_a, 16'h0030);
    cyc(2'b10);
    chk("run4.bcd_a", bcd_a, 16'h0029);
    chk("run4.tick_a", 16'(tick_a), 16'h0001);
    cyc(2'b10);
    chk("run5.tick_a", 16'(tick_a), 16'h0000);

    // Minute borrow from PRESET_B.
    cyc(2'b01);
    cycn(2'b10, 4);
    chk("borrow.bcd_a", bcd_a, 16'h0059);

    // Pause keeps the partial second.
    cyc(2'b00);
    cycn(2'b10, 2);
    cycn(2'b11, 10);
    chk("stop.bcd_a", bcd_a, 16'h0030);
    cyc(2'b10);
    chk("resume1.bcd_a", bcd_a, 16'h0030);
    cyc(2'b10);
    chk("resume2.bcd_a", bcd_a, 16'h0029);

    // Count to zero on the short instance, then saturate.
    cyc(2'b00);
    cycn(2'b10, 4);
    chk("short.bcd_b", bcd_b, 16'h0001);
    cycn(2'b10, 4);
    chk("zero.bcd_b", bcd_b, 16'h0000);
    chk("zero.zero_b", 16'(zero_b), 16'h0001);
    chk("zero.done_b", 16'(done_b), 16'h0001);
    cyc(2'b10);
    chk("zero.done_once", 16'(done_b), 16'h0000);
    cycn(2'b10, 3);
    chk("sat.tick_b", 16'(tick_b), 16'h0001);
    chk("sat.done_b", 16'(done_b), 16'h0000);
    cyc(2'b00);
    chk("reload.bcd_b", bcd_b, 16'h0002);
    chk("reload.zero_b", 16'(zero_b), 16'h0000);

    // Low-time band on the short instance (warn blink when enabled).
    cyc(2'b01);
    cycn(2'b10, 10);

    // Asynchronous reset between clock edges.
    cyc(2'b00);
    cycn(2'b10, 5);
    @(negedge clk);
    state = 2'b10;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("arst.bcd_a", bcd_a, 16'h0030);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all();

    // Random state sequences, weighted toward RUN.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      cyc(2'b00);
      else if (r == 1) cyc(2'b01);
      else if (r <= 7) cyc(2'b10);
      else             cyc(2'b11);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
